// File: rtl/pmul_pkg.sv
// Shared FSM encoding and derived-size helpers for the sequential GF(2)[x] multiplier.
package pmul_pkg;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_MUL  = 3'd2;
   localparam logic [2:0] S_ACC  = 3'd3;
   localparam logic [2:0] S_FIN  = 3'd4;

   function automatic int cdiv(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   function automatic int limb_w(input int n, input int k);
      return cdiv(n, k);
   endfunction

   function automatic int limb_cycles(input int n, input int k, input int d);
      return cdiv(cdiv(n, k), d);
   endfunction

   function automatic int acc_w(input int n, input int k);
      return 2 * k * cdiv(n, k);
   endfunction

endpackage

// File: rtl/pmul_limb_clmul.sv
// L x L carry-less multiplier, D bits of b per cycle, LSB digit first.
module pmul_limb_clmul
   import pmul_pkg::*;
#(
   parameter int L = 4,
   parameter int D = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           go,
   input  logic [L-1:0]   a,
   input  logic [L-1:0]   b,
   output logic [2*L-1:0] p,
   output logic           rdy
);

   localparam int LC = cdiv(L, D);
   localparam int BW = LC * D;
   localparam int CW = $clog2(LC + 1);

   logic [2*L-1:0] a_sh;
   logic [BW-1:0]  b_sh;
   logic [CW-1:0]  cnt;
   logic           run;
   logic [2*L-1:0] pp;

   // Bits shifted past 2L only pair with the zero padding of b, so truncation is exact.
   always_comb begin
      pp = '0;
      for (int d = 0; d < D; d++)
         if (b_sh[d]) pp = pp ^ (a_sh << d);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_sh <= '0;
         b_sh <= '0;
         cnt  <= '0;
         run  <= 1'b0;
         p    <= '0;
         rdy  <= 1'b0;
      end else begin
         rdy <= 1'b0;
         if (go) begin
            a_sh <= {{L{1'b0}}, a};
            b_sh <= BW'(b);
            cnt  <= '0;
            run  <= 1'b1;
            p    <= '0;
         end else if (run) begin
            p    <= p ^ pp;
            a_sh <= a_sh << D;
            b_sh <= b_sh >> D;
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(LC - 1)) begin
               run <= 1'b0;
               rdy <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/seq_poly_mul.sv
// Sequential carry-less polynomial multiplier over K x K limb products.
// Define PMUL_CYCLIC_EN to fold the result mod (x^N - 1) into an N-bit W.
module seq_poly_mul
   import pmul_pkg::*;
#(
   parameter int N = 17669,
   parameter int K = 4,
   parameter int D = 8,
`ifdef PMUL_CYCLIC_EN
   localparam int WW = N
`else
   localparam int WW = 2 * N
`endif
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [N-1:0]  U,
   input  logic [N-1:0]  V,
   output logic [WW-1:0] W,
   output logic          busy,
   output logic          done
);

   localparam int L  = limb_w(N, K);
   localparam int LC = limb_cycles(N, K, D);
   localparam int AW = acc_w(N, K);
   localparam int KL = K * L;
   localparam int IW = $clog2(K) + 1;
   localparam int CW = $clog2(LC) + 1;

   logic [2:0]     state;
   logic [IW-1:0]  i, j, ni, nj, si, sj;
   logic [CW-1:0]  mcnt;
   logic [KL-1:0]  u_ext, v_ext, u_r, v_r;
   logic [AW-1:0]  acc;
   logic [2*L-1:0] p;
   logic [WW-1:0]  w_next;
   logic           go, last, rdy;

   always_comb begin
      u_ext = '0;
      v_ext = '0;
      u_ext[N-1:0] = U;
      v_ext[N-1:0] = V;
   end

   assign last = (i == IW'(K - 1)) && (j == IW'(K - 1));
   assign busy = (state != S_IDLE);
   assign go   = (state == S_LOAD) || ((state == S_ACC) && !last);

   always_comb begin
      ni = i;
      nj = j + 1'b1;
      if (j == IW'(K - 1)) begin
         nj = '0;
         ni = i + 1'b1;
      end
   end

   // The limb multiplier samples operands on the same edge that advances i/j.
   always_comb begin
      si = i;
      sj = j;
      if (state == S_LOAD) begin
         si = '0;
         sj = '0;
      end else if (state == S_ACC) begin
         si = ni;
         sj = nj;
      end
   end

   pmul_limb_clmul #(.L(L), .D(D)) u_limb (
      .clk   (clk),
      .reset (reset),
      .go    (go),
      .a     (u_r[int'(si)*L +: L]),
      .b     (v_r[int'(sj)*L +: L]),
      .p     (p),
      .rdy   (rdy)
   );

`ifdef PMUL_CYCLIC_EN
   assign w_next = acc[N-1:0] ^ acc[2*N-1:N];
`else
   assign w_next = acc[2*N-1:0];
`endif

   // Padding limbs keep these accumulator bits at zero.
   generate
      if (AW > 2 * N) begin : g_pad
         logic acc_unused;
         assign acc_unused = |acc[AW-1:2*N];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         i     <= '0;
         j     <= '0;
         mcnt  <= '0;
         u_r   <= '0;
         v_r   <= '0;
         acc   <= '0;
         W     <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               u_r   <= u_ext;
               v_r   <= v_ext;
               state <= S_LOAD;
            end
            S_LOAD: begin
               acc   <= '0;
               i     <= '0;
               j     <= '0;
               mcnt  <= '0;
               state <= S_MUL;
            end
            S_MUL: begin
               mcnt <= mcnt + 1'b1;
               if (mcnt == CW'(LC - 1)) state <= S_ACC;
            end
            S_ACC: begin
               if (rdy) acc <= acc ^ (AW'(p) << ((int'(i) + int'(j)) * L));
               mcnt <= '0;
               if (last) begin
                  i     <= '0;
                  j     <= '0;
                  state <= S_FIN;
               end else begin
                  i     <= ni;
                  j     <= nj;
                  state <= S_MUL;
               end
            end
            S_FIN: begin
               W     <= w_next;
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
